// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_pkg
// Purpose  : Shared types and constants for the UART command scheduler.
//            Provides the scheduler state enum, the PING opcode and the
//            default ACK/NAK response bytes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DISPATCH = 3'd1,
    WAIT     = 3'd2,
    RESP     = 3'd3,
    TX_WAIT  = 3'd4
  } sched_state_t;

  localparam logic [3:0] OP_PING          = 4'h0;
  localparam logic [7:0] ACK_BYTE_DEFAULT = 8'hA5;
  localparam logic [7:0] NAK_BYTE_DEFAULT = 8'hFF;

endpackage : uart_cmd_pkg
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cmd_fifo
// Purpose  : Synchronous FIFO for queued commands. Push and pop may occur in
//            the same cycle; a push while full is accepted only if a pop
//            frees the slot on the same edge.
// Ports    : clk, rst_n       - clock, asynchronous active-low reset
//            push_i, wdata_i  - write strobe and data
//            pop_i, rdata_o   - read strobe and head-of-queue data
//            full_o, empty_o  - occupancy flags
//            count_o          - current occupancy
// Revision : 1.0 - initial release
// ============================================================================
module cmd_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int              AW       = $clog2(DEPTH);
  localparam logic [AW:0]     FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o    = (count_q == FULL_CNT);
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rd_ptr_q];

  assign w_do_pop  = pop_i & ~empty_o;
  // A pop on the same edge frees the slot, so a push into a full FIFO is legal.
  assign w_do_push = push_i & (~full_o | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule : cmd_fifo
`default_nettype wire

// File: rtl/uart_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_sched
// Purpose  : Queues 16-bit commands from the UART receiver, dispatches them
//            one at a time to the execution unit, waits for completion (or a
//            timeout) and returns a one-byte ACK/NAK via the UART transmitter.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            cmd, cmd_rdy          - command from receiver
//            clr_cmd_rdy           - command accepted this cycle
//            exec_cmd, exec_vld    - dispatch to execution unit
//            exec_done, exec_abort - completion in / abort out
//            tx_data, trmt, tx_done- transmitter handshake
//            fifo_cnt              - command FIFO occupancy
// Config   : UART_CMD_SCHED_TMO_EN - when defined, the completion timeout
//            counter, NAK response and exec_abort strobe are built.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_sched
  import uart_cmd_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] ACK_BYTE   = ACK_BYTE_DEFAULT,
  parameter logic [7:0] NAK_BYTE   = NAK_BYTE_DEFAULT,
  parameter int         TMO_CYCLES = 1_000_000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [15:0]                   cmd,
  input  logic                          cmd_rdy,
  output logic                          clr_cmd_rdy,
  output logic [15:0]                   exec_cmd,
  output logic                          exec_vld,
  input  logic                          exec_done,
  output logic                          exec_abort,
  output logic [7:0]                    tx_data,
  output logic                          trmt,
  input  logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  sched_state_t state_q, state_d;
  logic [15:0]  cur_cmd_q, cur_cmd_d;
  logic         ping_q, ping_d;
  logic [7:0]   tx_data_q, tx_data_d;

  logic         w_full;
  logic         w_empty;
  logic         w_pop;
  logic [15:0]  w_head;
  logic         w_tmo_hit;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  assign w_pop       = (state_q == IDLE) & ~w_empty;
  // A full FIFO still accepts when the head is popped on the same edge.
  assign clr_cmd_rdy = cmd_rdy & (~w_full | w_pop);

  cmd_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (clr_cmd_rdy),
    .wdata_i (cmd),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (fifo_cnt)
  );

  // ---------------------------------------------------------------------------
  // Completion timeout
  // ---------------------------------------------------------------------------
`ifdef UART_CMD_SCHED_TMO_EN
  localparam int               TMO_W    = $clog2(TMO_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == DISPATCH) begin
      tmo_cnt_d = '0;
    end else if (state_q == WAIT) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign w_tmo_hit  = (state_q == WAIT) && (tmo_cnt_q == TMO_LAST);
  // Completion on the expiry cycle takes priority, so suppress the abort.
  assign exec_abort = w_tmo_hit & ~exec_done;
`else
  assign w_tmo_hit  = 1'b0;
  assign exec_abort = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Scheduler FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cur_cmd_d = cur_cmd_q;
    ping_d    = ping_q;
    tx_data_d = tx_data_q;

    unique case (state_q)
      IDLE: begin
        if (w_pop) begin
          cur_cmd_d = w_head;
          ping_d    = (w_head[15:12] == OP_PING);
          state_d   = DISPATCH;
        end
      end
      DISPATCH: begin
        // PING passes through DISPATCH with the strobe masked, which places
        // its response two cycles after the pop.
        if (ping_q) begin
          tx_data_d = ACK_BYTE;
          state_d   = RESP;
        end else begin
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (exec_done || w_tmo_hit) begin
          tx_data_d = exec_done ? ACK_BYTE : NAK_BYTE;
          state_d   = RESP;
        end
      end
      RESP: begin
        state_d = TX_WAIT;
      end
      TX_WAIT: begin
        if (tx_done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_cmd_q <= '0;
      ping_q    <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cur_cmd_q <= cur_cmd_d;
      ping_q    <= ping_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign exec_cmd = cur_cmd_q;
  assign exec_vld = (state_q == DISPATCH) & ~ping_q;
  assign trmt     = (state_q == RESP);
  assign tx_data  = tx_data_q;

endmodule : uart_cmd_sched
`default_nettype wire
